// File: rtl/signature_run_controller.sv
// Two-pass signature run controller: resets the DUT, sweeps a 256-step stimulus,
// folds scrambled DUT observations into a signature and compares it per pass.
module signature_run_controller #(
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  seed_a,
    input  logic [7:0]  seed_b,
    input  logic [7:0]  dut_data,
    input  logic [15:0] expected_a,
    input  logic [15:0] expected_b,
    output logic        dut_sync_reset,
    output logic [7:0]  stimulus,
    output logic [7:0]  seed,
    output logic [15:0] signature,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_A,
        S_RUN_A,
        S_CHK_A,
        S_RST_B,
        S_RUN_B,
        S_CHK_B,
        S_DONE
    } state_t;

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_rst_cnt;
    logic        r_match_a;
    logic [7:0]  r_stimulus;
    logic [7:0]  r_seed;
    logic [15:0] r_signature;
    logic        r_done;
    logic        r_pass;

    logic        w_in_rst;
    logic        w_in_run;
    logic        w_enter_rst;
    logic        w_enter_rst_a;
    logic [7:0]  w_sum;

    assign w_in_rst      = (r_state == S_RST_A) || (r_state == S_RST_B);
    assign w_in_run      = (r_state == S_RUN_A) || (r_state == S_RUN_B);
    assign w_enter_rst_a = (w_next_state == S_RST_A) && (r_state != S_RST_A);
    assign w_enter_rst   = w_enter_rst_a ||
                           ((w_next_state == S_RST_B) && (r_state != S_RST_B));
    assign w_sum         = r_signature[7:0] + (dut_data ^ r_seed);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort overrides everything; start is only honoured when not busy.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) w_next_state = S_RST_A;
                S_RST_A:        if (r_rst_cnt == RST_LAST) w_next_state = S_RUN_A;
                S_RUN_A:        if (r_stimulus == 8'hFF) w_next_state = S_CHK_A;
                S_CHK_A:        w_next_state = S_RST_B;
                S_RST_B:        if (r_rst_cnt == RST_LAST) w_next_state = S_RUN_B;
                S_RUN_B:        if (r_stimulus == 8'hFF) w_next_state = S_CHK_B;
                S_CHK_B:        w_next_state = S_DONE;
                default:        w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_cnt   <= 4'd0;
            r_match_a   <= 1'b0;
            r_stimulus  <= 8'h00;
            r_seed      <= 8'h00;
            r_signature <= 16'h0000;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            if (w_in_rst && (w_next_state == r_state)) begin
                r_rst_cnt <= r_rst_cnt + 4'd1;
            end else begin
                r_rst_cnt <= 4'd0;
            end

            // Seed is registered from the next state so the output never follows an input combinationally.
            case (w_next_state)
                S_RST_A, S_RUN_A, S_CHK_A: r_seed <= seed_a;
                S_RST_B, S_RUN_B, S_CHK_B: r_seed <= seed_b;
                default:                   r_seed <= 8'h00;
            endcase

            if (abort) begin
                r_stimulus  <= 8'h00;
                r_signature <= 16'h0000;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_match_a   <= 1'b0;
            end else begin
                if (w_enter_rst) begin
                    r_stimulus  <= 8'h00;
                    r_signature <= 16'h0000;
                end else if (w_in_run) begin
                    r_signature <= {r_signature[14:8], w_sum, r_signature[15]};
                    r_stimulus  <= r_stimulus + 8'h01;
                end

                if (w_enter_rst_a) begin
                    r_done    <= 1'b0;
                    r_pass    <= 1'b0;
                    r_match_a <= 1'b0;
                end

                if (r_state == S_CHK_A) begin
                    r_match_a <= (r_signature == expected_a);
                end

                if (r_state == S_CHK_B) begin
                    r_pass <= r_match_a && (r_signature == expected_b);
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign dut_sync_reset = w_in_rst;
    assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign stimulus       = r_stimulus;
    assign seed           = r_seed;
    assign signature      = r_signature;
    assign done           = r_done;
    assign pass           = r_pass;

endmodule

// File: tb/tb_signature_run_controller.sv
// Randomized bench for signature_run_controller: each run is checked cycle by cycle
// against a timeline and signature model derived from the two-pass run rules.
module tb_signature_run_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  seed_a;
    logic [7:0]  seed_b;
    logic [7:0]  dut_data;
    logic [15:0] expected_a;
    logic [15:0] expected_b;
    logic        dut_sync_reset;
    logic [7:0]  stimulus;
    logic [7:0]  seed;
    logic [15:0] signature;
    logic        busy;
    logic        done;
    logic        pass;

    int testCount;
    int failCount;

    logic [7:0] dataA [256];
    logic [7:0] dataB [256];

    signature_run_controller #(.RST_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .seed_a         (seed_a),
        .seed_b         (seed_b),
        .dut_data       (dut_data),
        .expected_a     (expected_a),
        .expected_b     (expected_b),
        .dut_sync_reset (dut_sync_reset),
        .stimulus       (stimulus),
        .seed           (seed),
        .signature      (signature),
        .busy           (busy),
        .done           (done),
        .pass           (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Signature after folding the first n samples of a pass, using plain shifts and masks.
    function automatic logic [15:0] passSig(input logic [7:0] s, input bit useB, input int n);
        logic [15:0] acc;
        logic [7:0]  d;
        logic [7:0]  low;
        acc = 16'h0000;
        for (int i = 0; i < n; i++) begin
            d   = useB ? dataB[i] : dataA[i];
            low = acc[7:0] + (d ^ s);
            acc = ((acc & 16'h7F00) << 1) | (16'(low) << 1) | (acc >> 15);
        end
        return acc;
    endfunction

    task automatic fillData(input bit randomData);
        for (int i = 0; i < 256; i++) begin
            dataA[i] = randomData ? 8'($urandom) : 8'h00;
            dataB[i] = randomData ? 8'($urandom) : 8'h00;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".dsr"},  32'(dut_sync_reset), 32'd0);
        checkOutput({tag, ".stim"}, 32'(stimulus),       32'd0);
        checkOutput({tag, ".seed"}, 32'(seed),           32'd0);
        checkOutput({tag, ".sig"},  32'(signature),      32'd0);
        checkOutput({tag, ".busy"}, 32'(busy),           32'd0);
        checkOutput({tag, ".done"}, 32'(done),           32'd0);
        checkOutput({tag, ".pass"}, 32'(pass),           32'd0);
    endtask

    // Edge 0 samples start; RST_A follows for edges 0..3, pass A samples at edges 5..260,
    // CHK_A at 260, RST_B for 261..264, pass B samples at 266..521, done rises at edge 522.
    task automatic applyStimulus(input logic [7:0] sA, input logic [7:0] sB,
                                 input logic [15:0] eA, input logic [15:0] eB,
                                 input bit busyPulses, input int abortAt, input int resetAt);
        logic [15:0] sigA;
        logic [15:0] sigB;
        logic [15:0] expSig;
        logic [7:0]  expStim;
        logic [7:0]  expSeed;
        bit          expPass;
        sigA    = passSig(sA, 1'b0, 256);
        sigB    = passSig(sB, 1'b1, 256);
        expPass = (sigA == eA) && (sigB == eB);
        for (int k = 0; k <= 522; k++) begin
            @(negedge clk);
            if (k == 0) begin
                seed_a     = sA;
                seed_b     = sB;
                expected_a = eA;
                expected_b = eB;
            end
            start = (k == 0) || (busyPulses && (k == 100 || k == 522));
            abort = 1'b0;
            if (k >= 5 && k <= 260)
                dut_data = dataA[k-5];
            else if (k >= 266 && k <= 521)
                dut_data = dataB[k-266];
            else
                dut_data = 8'($urandom);

            if (k == resetAt) begin
                reset = 1'b0;
                #1;
                checkIdleOutputs($sformatf("asyncReset@%0d", k));
                #2;
                reset = 1'b1;
                start = 1'b0;
                return;
            end

            if (abortAt >= 0 && k == abortAt + 1) begin
                abort = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1;
                checkIdleOutputs($sformatf("abort@%0d", k));
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                @(posedge clk);
                #1;
                checkOutput("abortStartIgnored.busy", 32'(busy), 32'd0);
                checkOutput("abortStartIgnored.dsr",  32'(dut_sync_reset), 32'd0);
                return;
            end

            @(posedge clk);
            #1;
            if (k <= 260)
                expSig = passSig(sA, 1'b0, (k > 4) ? k - 4 : 0);
            else if (k <= 265)
                expSig = 16'h0000;
            else
                expSig = passSig(sB, 1'b1, (k - 265 > 256) ? 256 : k - 265);
            if (k >= 5 && k <= 259)
                expStim = 8'(k - 4);
            else if (k >= 266 && k <= 520)
                expStim = 8'(k - 265);
            else
                expStim = 8'h00;
            expSeed = (k <= 260) ? sA : (k < 522) ? sB : 8'h00;

            checkOutput($sformatf("dsr@%0d", k),  32'(dut_sync_reset), 32'((k <= 3) || (k >= 261 && k <= 264)));
            checkOutput($sformatf("busy@%0d", k), 32'(busy),           32'(k < 522));
            checkOutput($sformatf("stim@%0d", k), 32'(stimulus),       32'(expStim));
            checkOutput($sformatf("seed@%0d", k), 32'(seed),           32'(expSeed));
            checkOutput($sformatf("sig@%0d", k),  32'(signature),      32'(expSig));
            checkOutput($sformatf("done@%0d", k), 32'(done),           32'(k == 522));
            checkOutput($sformatf("pass@%0d", k), 32'(pass),           32'((k == 522) && expPass));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] sA;
        logic [7:0] sB;
        testCount  = 0;
        failCount  = 0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        seed_a     = 8'h00;
        seed_b     = 8'h00;
        dut_data   = 8'h00;
        expected_a = 16'h0000;
        expected_b = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("inReset");
        #1;
        reset = 1'b1;

        // Zero run straight out of reset: expected signatures of zero must pass.
        fillData(1'b0);
        applyStimulus(8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, -1, -1);
        checkOutput("zeroRun.pass", 32'(pass), 32'd1);

        // First-update values plus ignored start pulses mid-run, restarting from DONE.
        applyStimulus(8'h01, 8'h00, 16'h1234, 16'h0000, 1'b1, -1, -1);
        checkOutput("firstUpdate.sigB", 32'(signature), 32'd0);

        applyStimulus(8'h00, 8'h00, 16'h0001, 16'h0000, 1'b0, -1, -1);
        checkOutput("mismatchA.pass", 32'(pass), 32'd0);
        applyStimulus(8'h00, 8'h00, 16'h0000, 16'h8000, 1'b0, -1, -1);
        checkOutput("mismatchB.pass", 32'(pass), 32'd0);

        // Random data with golden values taken from the model so the run passes.
        fillData(1'b1);
        sA = 8'($urandom);
        sB = 8'($urandom);
        applyStimulus(sA, sB, passSig(sA, 1'b0, 256), passSig(sB, 1'b1, 256), 1'b1, -1, -1);
        checkOutput("randomMatch.pass", 32'(pass), 32'd1);

        abort = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("abortInDone");
        @(negedge clk);
        abort = 1'b0;

        // Pass A correct but pass B off by one bit must still fail overall.
        fillData(1'b1);
        sA = 8'($urandom);
        sB = 8'($urandom);
        applyStimulus(sA, sB, passSig(sA, 1'b0, 256), passSig(sB, 1'b1, 256) ^ 16'h0010, 1'b0, -1, -1);
        checkOutput("randomMismatchB.pass", 32'(pass), 32'd0);

        fillData(1'b1);
        applyStimulus(8'($urandom), 8'($urandom), 16'h0000, 16'h0000, 1'b0, 68, -1);

        fillData(1'b1);
        applyStimulus(8'($urandom), 8'($urandom), 16'h0000, 16'h0000, 1'b0, -1, 300);

        fillData(1'b1);
        sA = 8'($urandom);
        sB = 8'($urandom);
        applyStimulus(sA, sB, passSig(sA, 1'b0, 256), passSig(sB, 1'b1, 256), 1'b0, -1, -1);
        checkOutput("afterReset.pass", 32'(pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/signature_run_controller.md
SIGNATURE_RUN_CONTROLLER -- requirements
Module: signature_run_controller

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of clocks the DUT sync reset is held at the start of each pass; legal range 1..15.
REQ-002 clk  input  1  rising-edge system clock; all state changes occur on this edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 start  input  1  request to begin a two-pass run; sampled on clk.
REQ-005 abort  input  1  synchronous request to cancel a run; sampled on clk.
REQ-006 seed_a, seed_b  input  8 each  scrambler seeds for pass A and pass B.
REQ-007 dut_data  input  8  scrambled DUT observation bus, sampled every RUN clock.
REQ-008 expected_a, expected_b  input  16 each  golden signatures for pass A and pass B.
REQ-009 dut_sync_reset  output  1  active-high reset driven to the DUT.
REQ-010 stimulus  output  8  stimulus counter driven to the DUT.
REQ-011 seed  output  8  seed for the active pass.
REQ-012 signature  output  16  current signature register value.
REQ-013 busy, done, pass  output  1 each  run status flags.

Function
REQ-014 States: IDLE, RST_A, RUN_A, CHK_A, RST_B, RUN_B, CHK_B, DONE; all outputs are registered or decoded from state only, with no combinational path from any input to any output.
- IDLE/DONE + start=1 -> RST_A.
- RST_x lasts RST_CYCLES clocks, then -> RUN_x.
- RUN_x -> CHK_x on the clock where stimulus==8'hFF.
- CHK_A -> RST_B; CHK_B -> DONE.
REQ-015 Entering RST_A or RST_B clears signature to 16'h0000 and stimulus to 8'h00.
- dut_sync_reset=1 only in RST_A/RST_B.
REQ-016 In RUN_x, each clock:
- signature <= {signature[14:8], (signature[7:0] + (dut_data ^ seed))[7:0], signature[15]}; the 8-bit sum discards its carry.
- stimulus <= stimulus + 1, wrapping 8'hFF -> 8'h00.
- A pass therefore accumulates exactly 256 samples.
REQ-017 seed output:
- seed_a in RST_A/RUN_A/CHK_A.
- seed_b in RST_B/RUN_B/CHK_B.
- 8'h00 in IDLE/DONE.
REQ-018 CHK_A lasts 1 clock and latches match_a <= (signature==expected_a).
REQ-019 CHK_B lasts 1 clock and sets pass <= match_a & (signature==expected_b) and done <= 1.
REQ-020 Signature and stimulus hold their values in CHK_x and DONE.
REQ-021 busy=1 in every state except IDLE and DONE.
REQ-022 Restart from DONE:
- start in DONE clears done and pass on the same edge that enters RST_A.
- done and pass are otherwise held in DONE.
REQ-023 start is ignored while busy=1.
REQ-024 abort=1 from any state -> IDLE on the next edge, with stimulus=0, signature=0, done=0, pass=0, match_a=0.
REQ-025 abort has priority over start when both are asserted on the same edge.
REQ-026 Latency: done rises exactly 2*(RST_CYCLES+256+1) clocks after the edge that samples start (522 clocks with the default RST_CYCLES).

Reset
REQ-027 reset=0 asynchronously forces the following, independent of clk:
- state=IDLE, rst_cnt=0, match_a=0.
- stimulus=8'h00, signature=16'h0000, seed=8'h00.
- dut_sync_reset=0, busy=0, done=0, pass=0.
REQ-028 Reset release: the first start can be sampled on the first clk edge after reset returns high.

Verification
REQ-029 Zero run: seeds=0, dut_data=0, expected_a=expected_b=0, start pulse -> busy=1 after the next edge; done=1, pass=1 exactly 522 clocks after start; signature=16'h0000.
REQ-030 First update: seed_a=8'h01, dut_data=8'h00 -> signature=16'h0002 after the first RUN_A clock and 16'h0006 after the second.
REQ-031 Mismatch: zero run with expected_a=16'h0001 -> done=1, pass=0; repeating with expected_a=0 and expected_b=16'h8000 -> pass=0.
REQ-032 Abort: assert abort when stimulus=8'h40 in RUN_A -> IDLE next edge, busy=0, stimulus=0, signature=0; start asserted on that same edge is ignored.
REQ-033 Async reset mid-RUN_B: drive reset=0 between clock edges -> all outputs reach reset values before the next edge; a start after release completes a full 522-clock run.
REQ-034 Busy start and restart:
- start pulses during RUN_A and CHK_B -> no effect on state or timing.
- start in DONE -> done=0 and dut_sync_reset=1 for 4 clocks.
